// File: rtl/dbus_arbiter.sv
// Four-requester round-robin data-bus arbiter with a one-cycle turnaround between owners.
// Optional hold-time preemption is enabled by defining DBUS_ARB_PREEMPT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate any pending request
// OWN   | gnt[owner] driven, bus enabled
// TURN  | one dead cycle with gnt=0 and the bus released, then re-arbitrate
module dbus_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [15:0] din2,
    input  logic [15:0] din3,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        dbus_oe,
    output logic [15:0] dbus,
    output logic        preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  gnt_nxt;
    logic [1:0]  owner_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic        oe_nxt;
    logic        armed;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        grab;
    logic        release_bus;
    logic        force_rel;

    // Search order starts one past the last winner and wraps; rr_ptr itself is tried last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        oe_nxt      = dbus_oe;
        grab        = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: grab = armed && win_vld;
            OWN:  release_bus = !req[owner] || force_rel;
            TURN: begin
                if (win_vld) grab = 1'b1;
                else         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (grab) begin
            state_nxt  = OWN;
            gnt_nxt    = 4'b0001 << win_idx;
            owner_nxt  = win_idx;
            rr_ptr_nxt = win_idx;
            oe_nxt     = 1'b1;
        end
        if (release_bus) begin
            state_nxt = TURN;
            gnt_nxt   = 4'b0000;
            oe_nxt    = 1'b0;
        end
    end

    // armed holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            owner   <= 2'd0;
            dbus_oe <= 1'b0;
            rr_ptr  <= 2'd3;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            owner   <= owner_nxt;
            dbus_oe <= oe_nxt;
            rr_ptr  <= rr_ptr_nxt;
            armed   <= 1'b1;
        end
    end

`ifdef DBUS_ARB_PREEMPT_EN
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic          preempt_nxt;

    assign force_rel = (state == OWN) && (hold_cnt == HW'(HOLD_MAX)) && !lock[owner]
                       && ((req & ~gnt) != 4'b0000);

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        preempt_nxt  = 1'b0;
        if (grab) begin
            hold_cnt_nxt = '0;
        end else if (state == OWN && hold_cnt != HW'(HOLD_MAX)) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
        // A release the owner asked for anyway is not reported as a preemption.
        if (force_rel && req[owner]) preempt_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            preempt  <= preempt_nxt;
        end
    end
`else
    logic [7:0] unused_cfg;

    assign force_rel  = 1'b0;
    assign preempt    = 1'b0;
    assign unused_cfg = 8'(HOLD_MAX) ^ {4'd0, lock};
`endif

    always_comb begin
        dbus = 16'h0000;
        if (dbus_oe) begin
            case (owner)
                2'd0:    dbus = din0;
                2'd1:    dbus = din1;
                2'd2:    dbus = din2;
                default: dbus = din3;
            endcase
        end
    end

endmodule
